// File: rtl/param_comb_lock.sv
// param_comb_lock: parametrised sequential combination lock.
// Accepts a code of SEQ_LEN one-hot button presses from N_BTN buttons. It opens for
// UNLOCK_CYC cycles on a correct code, locks out for LOCKOUT_CYC cycles after MAX_FAIL
// wrong codes, discards an entry after TIMEOUT_CYC idle cycles, and honours an early relock.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   comb_i     - button levels, already synchronised to clk
//   relock_i   - forces an early relock while unlocked
//   unlock_o   - lock open (registered)
//   lockout_o  - lockout in progress (registered)
//   busy_o     - code entry in progress (registered)
//   fail_cnt_o - failed attempts since the last success or lockout (registered)
module param_comb_lock #(
    parameter int unsigned              N_BTN       = 3,
    parameter int unsigned              SEQ_LEN     = 4,
    parameter logic [SEQ_LEN*N_BTN-1:0] CODE        = {3'b100, 3'b010, 3'b100, 3'b001},
    parameter int unsigned              MAX_FAIL    = 3,
    parameter int unsigned              TIMEOUT_CYC = 500,
    parameter int unsigned              UNLOCK_CYC  = 200,
    parameter int unsigned              LOCKOUT_CYC = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_BTN-1:0]              comb_i,
    input  logic                          relock_i,
    output logic                          unlock_o,
    output logic                          lockout_o,
    output logic                          busy_o,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt_o
);

    localparam int unsigned FailW  = $clog2(MAX_FAIL + 1);
    localparam int unsigned IdxW   = $clog2(SEQ_LEN + 1);
    localparam int unsigned MaxUL  = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int unsigned MaxCyc = (TIMEOUT_CYC > MaxUL) ? TIMEOUT_CYC : MaxUL;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    typedef enum logic [1:0] {
        StIdle,
        StEntry,
        StUnlocked,
        StLockout
    } state_e;

    state_e            state_q;
    logic [N_BTN-1:0]  comb_q;
    logic [IdxW-1:0]   idx_q;
    logic              err_q;
    logic [CntW-1:0]   cnt_q;
    logic [FailW-1:0]  fail_q;

    logic [N_BTN-1:0]  step_code;
    logic [CntW-1:0]   cnt_inc;
    logic              press;
    logic              step_ok;
    logic              last_step;
    logic              err_eval;
    logic              fail_last;

    // Code step selected by the current index.
    always_comb begin
        step_code = '0;
        for (int unsigned i = 0; i < SEQ_LEN; i++) begin
            if (idx_q == IdxW'(i)) begin
                step_code = CODE[i*N_BTN +: N_BTN];
            end
        end
    end

    always_comb begin
        // Rising edge of "any button": holding a button never re-triggers.
        press     = (comb_i != '0) && (comb_q == '0);
        // A multi-button press can never match a one-hot step.
        step_ok   = $onehot(comb_i) && (comb_i == step_code);
        // idx is 0 in IDLE, so this also covers a one-step code pressed from IDLE.
        last_step = (idx_q == IdxW'(SEQ_LEN - 1));
        err_eval  = err_q | ~step_ok;
        fail_last = (fail_q == FailW'(MAX_FAIL - 1));
        cnt_inc   = (cnt_q == CntW'(MaxCyc)) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            comb_q    <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            fail_q    <= '0;
            unlock_o  <= 1'b0;
            lockout_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            comb_q <= comb_i;
            unique case (state_q)
                StIdle, StEntry: begin
                    if (press) begin
                        cnt_q <= '0;
                        if (last_step) begin
                            // Evaluate in the same edge as the final press.
                            idx_q  <= '0;
                            err_q  <= 1'b0;
                            busy_o <= 1'b0;
                            if (!err_eval) begin
                                state_q  <= StUnlocked;
                                unlock_o <= 1'b1;
                                fail_q   <= '0;
                            end else if (fail_last) begin
                                state_q   <= StLockout;
                                lockout_o <= 1'b1;
                                fail_q    <= FailW'(MAX_FAIL);
                            end else begin
                                state_q <= StIdle;
                                fail_q  <= fail_q + 1'b1;
                            end
                        end else begin
                            state_q <= StEntry;
                            busy_o  <= 1'b1;
                            idx_q   <= idx_q + 1'b1;
                            err_q   <= err_eval;
                        end
                    end else if (state_q == StEntry) begin
                        if (cnt_q >= CntW'(TIMEOUT_CYC - 1)) begin
                            // Abandoned entry: discard without counting a failure.
                            state_q <= StIdle;
                            busy_o  <= 1'b0;
                            idx_q   <= '0;
                            err_q   <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end
                end
                StUnlocked: begin
                    if (relock_i || (cnt_q >= CntW'(UNLOCK_CYC - 1))) begin
                        state_q  <= StIdle;
                        unlock_o <= 1'b0;
                        cnt_q    <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StLockout: begin
                    if (cnt_q >= CntW'(LOCKOUT_CYC - 1)) begin
                        state_q   <= StIdle;
                        lockout_o <= 1'b0;
                        fail_q    <= '0;
                        cnt_q     <= '0;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
            endcase
        end
    end

    assign fail_cnt_o = fail_q;

endmodule

// File: tb/tb_param_comb_lock.sv
// Scoreboard bench for param_comb_lock. Stimulus pushes the expected output vector
// {unlock, lockout, busy, fail_cnt} together with the edge at which it must appear; the
// monitor pops an entry whenever the sampled outputs change and checks value and edge.
module tb_param_comb_lock;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] comb = '0;
    logic       relock = 1'b0;
    logic       unlock;
    logic       lockout;
    logic       busy;
    logic [1:0] fail_cnt;

    param_comb_lock #(
        .N_BTN      (3),
        .SEQ_LEN    (4),
        .CODE       (12'b100_010_100_001),
        .MAX_FAIL   (3),
        .TIMEOUT_CYC(20),
        .UNLOCK_CYC (10),
        .LOCKOUT_CYC(50)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .comb_i    (comb),
        .relock_i  (relock),
        .unlock_o  (unlock),
        .lockout_o (lockout),
        .busy_o    (busy),
        .fail_cnt_o(fail_cnt)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct packed {
        int         at;
        logic [4:0] val;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;

    function automatic void expect_ev(input int at, input logic u, input logic l,
                                      input logic b, input logic [1:0] fc);
        ev_t e;
        e.at  = at;
        e.val = {u, l, b, fc};
        exp_q.push_back(e);
    endfunction

    // Monitor: all comparisons live here.
    logic [4:0] last_v = '0;
    always @(negedge clk) begin : mon
        logic [4:0] cur;
        ev_t        e;
        cur = {unlock, lockout, busy, fail_cnt};
        if (!rst_n) begin
            n_cmp++;
            if (cur !== 5'b0) begin
                n_bad++;
                $display("FAIL reset_state edge %0d: got %b, required 00000", edge_n, cur);
            end
        end else if (cur !== last_v) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change edge %0d: got %b, required no change",
                         edge_n, cur);
            end else begin
                e = exp_q.pop_front();
                if (e.val !== cur || e.at != edge_n) begin
                    n_bad++;
                    $display("FAIL event: got %b at edge %0d, required %b at edge %0d",
                             cur, edge_n, e.val, e.at);
                end
            end
        end
        last_v = cur;
        if (done) begin
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL pending_events: got %0d outstanding (next at edge %0d), required 0",
                         exp_q.size(), exp_q[0].at);
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    // Wait (at a falling edge) until the next rising edge is edge e.
    task automatic go(input int e);
        while (edge_n < e - 1) @(negedge clk);
    endtask

    task automatic tap(input logic [2:0] btn, input int e);
        go(e);
        comb = btn;
        @(negedge clk);
        comb = '0;
    endtask

    // Four presses at b, b+7, b+17, b+27; the last press lands on edge b+27.
    task automatic entry(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2,
                         input logic [2:0] s3, input int b);
        tap(s0, b);
        tap(s1, b + 7);
        tap(s2, b + 17);
        tap(s3, b + 27);
    endtask

    // Correct code expected to unlock, starting from fail count fc0.
    task automatic good_code(input logic [1:0] fc0);
        int b;
        b = edge_n + 2;
        expect_ev(b, 1'b0, 1'b0, 1'b1, fc0);
        expect_ev(b + 27, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_ev(b + 37, 1'b0, 1'b0, 1'b0, 2'd0);
        entry(3'b001, 3'b100, 3'b010, 3'b100, b);
        go(b + 40);
    endtask

    // Wrong code (last step wrong) from fail count fc0.
    task automatic bad_code(input logic [1:0] fc0, output int last);
        int b;
        b = edge_n + 2;
        last = b + 27;
        expect_ev(b, 1'b0, 1'b0, 1'b1, fc0);
        if (fc0 == 2'd2) begin
            expect_ev(last, 1'b0, 1'b1, 1'b0, 2'd3);
            expect_ev(last + 50, 1'b0, 1'b0, 1'b0, 2'd0);
        end else begin
            expect_ev(last, 1'b0, 1'b0, 1'b0, fc0 + 2'd1);
        end
        entry(3'b001, 3'b100, 3'b010, 3'b010, b);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int b;
        int l;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: correct code
        good_code(2'd0);

        // 2: multi-bit step counts as wrong, then a correct code clears the count
        b = edge_n + 2;
        expect_ev(b, 1'b0, 1'b0, 1'b1, 2'd0);
        expect_ev(b + 27, 1'b0, 1'b0, 1'b0, 2'd1);
        entry(3'b001, 3'b110, 3'b010, 3'b100, b);
        go(b + 30);
        good_code(2'd1);

        // 3: lockout; correct code and relock ignored during it
        bad_code(2'd0, l);
        go(l + 3);
        bad_code(2'd1, l);
        go(l + 3);
        bad_code(2'd2, l);
        entry(3'b001, 3'b100, 3'b010, 3'b100, l + 5);
        go(l + 40);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        go(l + 53);
        good_code(2'd0);

        // 4: timeout discards the entry; new entry starts at 010
        b = edge_n + 2;
        expect_ev(b, 1'b0, 1'b0, 1'b1, 2'd0);
        expect_ev(b + 27, 1'b0, 1'b0, 1'b0, 2'd0);
        tap(3'b001, b);
        tap(3'b100, b + 7);
        go(b + 30);
        b = b + 30;
        expect_ev(b, 1'b0, 1'b0, 1'b1, 2'd0);
        expect_ev(b + 27, 1'b0, 1'b0, 1'b0, 2'd1);
        entry(3'b010, 3'b100, 3'b001, 3'b100, b);
        // 4b: presses landing exactly on the timeout edge still count
        b = b + 32;
        expect_ev(b, 1'b0, 1'b0, 1'b1, 2'd1);
        expect_ev(b + 60, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_ev(b + 70, 1'b0, 1'b0, 1'b0, 2'd0);
        tap(3'b001, b);
        tap(3'b100, b + 20);
        tap(3'b010, b + 40);
        tap(3'b100, b + 60);
        go(b + 73);

        // 5: relock 3 cycles after unlock; final button held through return to IDLE
        b = edge_n + 2;
        l = b + 27;
        expect_ev(b, 1'b0, 1'b0, 1'b1, 2'd0);
        expect_ev(l, 1'b1, 1'b0, 1'b0, 2'd0);
        expect_ev(l + 3, 1'b0, 1'b0, 1'b0, 2'd0);
        tap(3'b001, b);
        tap(3'b100, b + 7);
        tap(3'b010, b + 17);
        go(l);
        comb = 3'b100;
        go(l + 3);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        go(l + 30);
        comb = '0;
        go(l + 35);

        // 6a: reset mid-entry with a nonzero fail count
        bad_code(2'd0, l);
        b = l + 5;
        expect_ev(b, 1'b0, 1'b0, 1'b1, 2'd1);
        tap(3'b001, b);
        tap(3'b100, b + 7);
        go(b + 10);
        do_reset();
        good_code(2'd0);

        // 6b: reset mid-lockout
        bad_code(2'd0, l);
        go(l + 3);
        bad_code(2'd1, l);
        go(l + 3);
        bad_code(2'd2, l);
        go(l + 20);
        do_reset();
        good_code(2'd0);

        repeat (5) @(negedge clk);
        #1;
        done = 1'b1;
    end

endmodule

// File: doc/param_comb_lock.md
# param_comb_lock

Parametrised sequential combination lock: the next generation of the 3-button lock. It accepts a code of `SEQ_LEN` one-hot button presses from `N_BTN` buttons and asserts `unlock` for a fixed hold time on a correct sequence. It adds an entry timeout, a failed-attempt counter with timed lockout, and an early relock input. It sits between the synchronised button inputs and the lock actuator/LED driver.

## Interface
- `N_BTN`, 3: number of buttons (≥2).
- `SEQ_LEN`, 4: presses per code (≥1).
- `CODE`, {3'b100,3'b010,3'b100,3'b001}: `SEQ_LEN*N_BTN` bits. Step i occupies `CODE[i*N_BTN +: N_BTN]`, step 0 is the first press, and each step is one-hot.
- `MAX_FAIL`, 3: failed attempts that trigger lockout (≥1).
- `TIMEOUT_CYC`, 500: idle cycles allowed between presses in an entry (≥1).
- `UNLOCK_CYC`, 200: cycles `unlock` is held (≥1).
- `LOCKOUT_CYC`, 1000: cycles of lockout (≥1).
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `comb`  input  `N_BTN`  button levels, already synchronised to `clk`.
- `relock`  input  1  forces an early relock while unlocked.
- `unlock`  output  1  lock open.
- `lockout`  output  1  lockout in progress.
- `busy`  output  1  code entry in progress.
- `fail_cnt`  output  `$clog2(MAX_FAIL+1)`  failed attempts since the last success or lockout.

## Operation
- Press detection:
  - `comb_q` registers `comb` every cycle, in all states.
  - A press event occurs at the edge where `comb != 0` and `comb_q == 0`.
  - A press is *valid* only if `comb` is one-hot. A multi-button press counts as a wrong step.
  - Holding a button generates no further events.
- States and transitions:
  - IDLE:
    - A press compares against step 0, sets `err` if it mismatches, and sets `idx=1`.
    - Goes to ENTRY, or straight to EVAL if `SEQ_LEN==1`.
  - ENTRY:
    - Each press compares against step `idx`, ORs any mismatch into `err`, and increments `idx`.
    - The press that makes `idx==SEQ_LEN` goes to EVAL.
    - No hint is given on a mismatch; entry continues to full length.
  - ENTRY timeout:
    - The timer clears on entry to ENTRY and on every press.
    - After `TIMEOUT_CYC` consecutive cycles with no press, go to IDLE.
    - The entry is discarded and `fail_cnt` is unchanged.
  - EVAL is evaluated in the same edge as the final press, not a separate cycle:
    - `err==0`: go to UNLOCKED and clear `fail_cnt`.
    - `err==1` and `fail_cnt+1 < MAX_FAIL`: increment `fail_cnt`, go to IDLE.
    - `err==1` and `fail_cnt+1 == MAX_FAIL`: go to LOCKOUT with `fail_cnt=MAX_FAIL`.
  - UNLOCKED:
    - Stays for `UNLOCK_CYC` cycles, then goes to IDLE.
    - `relock=1` goes to IDLE at the next edge.
    - Presses are ignored.
  - LOCKOUT:
    - Stays for `LOCKOUT_CYC` cycles, then goes to IDLE and clears `fail_cnt`.
    - Presses and `relock` are ignored.
- Outputs:
  - All outputs are registered.
  - `unlock`=UNLOCKED, `lockout`=LOCKOUT, `busy`=ENTRY.
  - `idx` and `err` clear whenever the FSM leaves ENTRY.
- Widths:
  - `idx` is `$clog2(SEQ_LEN+1)` bits.
  - One shared cycle counter is sized to the maximum of the three `*_CYC` parameters.
  - Counters saturate and never wrap.

## Timing
- Reset (async assert, sync release): state=IDLE, and `unlock=0`, `lockout=0`, `busy=0`, `fail_cnt=0`, `comb_q=0`, `idx=0`, `err=0`.
- Reset mid-entry or mid-lockout aborts immediately with no residual count.
- Latency: the final press sampled at edge k makes `unlock` (or `lockout`) high after edge k.
- `unlock` stays high for exactly `UNLOCK_CYC` cycles and falls after edge k+`UNLOCK_CYC`. `lockout` follows the same rule with `LOCKOUT_CYC`.
- `relock` sampled high at edge m (m>k) makes `unlock` low after edge m.
- A press in the same edge in which the timeout expires is counted as a press; the timer clears.
- A button already held when the FSM returns to IDLE produces no event until it is released and pressed again.

## Test plan
Bench overrides: `TIMEOUT_CYC=20`, `UNLOCK_CYC=10`, `LOCKOUT_CYC=50`, default `CODE` (001,100,010,100).
1. Correct code: 001,100,010,100 with 5–15 cycle gaps -> `busy=1` after the first press; `unlock=1` after the 4th press edge for exactly 10 cycles; `fail_cnt=0`.
2. Wrong or multi-bit step: 001,110,010,100 -> no unlock; `fail_cnt=1`; `busy=0`. A following correct code -> unlock and `fail_cnt=0`.
3. Lockout: three wrong 4-press codes -> `lockout=1` for 50 cycles. A correct code entered during lockout -> no unlock. After lockout, `fail_cnt=0` and a correct code unlocks.
4. Timeout: 001,100, then 20 idle cycles -> `busy=0`, `fail_cnt` unchanged. Then 010,100,001,100 -> `fail_cnt` +1 (a new entry started at 010).
5. Relock and hold: correct code, `relock` pulse 3 cycles later -> `unlock=0` at the next edge. A button held from before unlock through the return to IDLE generates no event.
6. Reset mid-entry (after 2 presses) and mid-lockout -> all outputs 0 immediately; the next correct code unlocks.
